// File: rtl/jtcontra_snd_pkg.sv
// Shared types and constants for the Contra sound post-mix stage.
// FSM encoding, saturation limits and the unity gain value.
package jtcontra_snd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L_DC,
        L_GAIN,
        R_DC,
        R_GAIN,
        OUT
    } state_t;

    localparam int YW_DEF = 20;

    localparam logic signed [15:0] S16_MAX = 16'sh7fff;
    localparam logic signed [15:0] S16_MIN = 16'sh8000;

    localparam logic signed [YW_DEF-1:0] SYW_MAX = {1'b0, {(YW_DEF-1){1'b1}}};
    localparam logic signed [YW_DEF-1:0] SYW_MIN = {1'b1, {(YW_DEF-1){1'b0}}};

    localparam logic [7:0] GAIN_UNITY = 8'h10;

endpackage

// File: rtl/jtcontra_snd_sat.sv
// Combinational saturating narrow of a signed value.
// Clips IW-bit input to the OW-bit two's complement range.
module jtcontra_snd_sat #(
    parameter int IW = 25,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam int XW = IW - OW + 1;

    logic [XW-1:0] top_bits;

    assign top_bits = din[IW-1:OW-1];

    // pass low bits when the discarded top bits are pure sign, else clip
    always_comb begin
        dout = din[OW-1:0];
        if (top_bits != {XW{din[IW-1]}}) begin
            dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}}
                             : {1'b0, {(OW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/jtcontra_snd_mix.sv
// Contra FM post-processing: DC-removal high-pass, gain, clip.
// One shared datapath walks left then right per sample edge.
module jtcontra_snd_mix
    import jtcontra_snd_pkg::*;
#(
    parameter int DC_SHIFT = 8,
    parameter int DC_EN    = 1,
    parameter int YW       = YW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_in,
    input  logic signed [15:0] left_in,
    input  logic signed [15:0] right_in,
    input  logic        [7:0]  gain,
    input  logic               mute,
    output logic signed [15:0] snd_left,
    output logic signed [15:0] snd_right,
    output logic               sample,
    output logic               overrun
);

    state_t st;

    logic sample_d;
    logic new_smp;

    logic signed [15:0]   xl, xr;
    logic signed [YW-1:0] xl1, yl1, xr1, yr1;
    logic signed [YW-1:0] yreg;
    logic signed [15:0]   hold_l;

    logic                 is_r;
    logic signed [15:0]   x16;
    logic signed [YW-1:0] xs, x1s, y1s, ysh;
    logic signed [YW+1:0] acc;
    logic signed [YW-1:0] ydc, y_dc;

    logic signed [15:0] ys;
    logic        [24:0] ys25, g25;
    logic signed [24:0] p, pr;
    logic signed [15:0] rg;

    assign new_smp = sample_in & ~sample_d;

    // select the channel being filtered and form the high-pass sum
    always_comb begin
        is_r = (st == R_DC);
        x16  = is_r ? xr : xl;
        xs   = {{(YW-16){x16[15]}}, x16};
        x1s  = is_r ? xr1 : xl1;
        y1s  = is_r ? yr1 : yl1;
        ysh  = y1s >>> DC_SHIFT;
        acc  = {{2{xs[YW-1]}}, xs}
             - {{2{x1s[YW-1]}}, x1s}
             + {{2{y1s[YW-1]}}, y1s}
             - {{2{ysh[YW-1]}}, ysh};
    end

    jtcontra_snd_sat #(.IW(YW+2), .OW(YW)) u_sat_yw (
        .din  (acc),
        .dout (ydc)
    );

    // bypass the filter entirely when it is disabled
    always_comb begin
        y_dc = xs;
        if (DC_EN != 0) y_dc = ydc;
    end

    jtcontra_snd_sat #(.IW(YW), .OW(16)) u_sat_in (
        .din  (yreg),
        .dout (ys)
    );

    // 16 x unsigned 8-bit product; low 25 bits are sign-agnostic
    always_comb begin
        ys25 = {{9{ys[15]}}, ys};
        g25  = {17'd0, gain};
        p    = ys25 * g25;
        pr   = p >>> 4;
    end

    jtcontra_snd_sat #(.IW(25), .OW(16)) u_sat_out (
        .din  (pr),
        .dout (rg)
    );

    // sequencer: outputs are loaded in R_GAIN so they show during OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            sample_d  <= 1'b0;
            sample    <= 1'b0;
            overrun   <= 1'b0;
            snd_left  <= '0;
            snd_right <= '0;
            xl        <= '0;
            xr        <= '0;
            xl1       <= '0;
            yl1       <= '0;
            xr1       <= '0;
            yr1       <= '0;
            yreg      <= '0;
            hold_l    <= '0;
        end else begin
            sample_d <= sample_in;
            sample   <= 1'b0;
            if (new_smp && st != IDLE) overrun <= 1'b1;
            unique case (st)
                IDLE: begin
                    if (new_smp) begin
                        xl <= left_in;
                        xr <= right_in;
                        st <= L_DC;
                    end
                end
                L_DC: begin
                    yreg <= y_dc;
                    if (DC_EN != 0) begin
                        xl1 <= xs;
                        yl1 <= ydc;
                    end
                    st <= L_GAIN;
                end
                L_GAIN: begin
                    hold_l <= rg;
                    st     <= R_DC;
                end
                R_DC: begin
                    yreg <= y_dc;
                    if (DC_EN != 0) begin
                        xr1 <= xs;
                        yr1 <= ydc;
                    end
                    st <= R_GAIN;
                end
                R_GAIN: begin
                    snd_left  <= mute ? '0 : hold_l;
                    snd_right <= mute ? '0 : rg;
                    sample    <= 1'b1;
                    st        <= OUT;
                end
                OUT: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtcontra_snd_mix.sv
// Bench for jtcontra_snd_mix: bypass and filtered instances side by side.
// Expected values come from an integer model of the filter/gain rules.
module tb_jtcontra_snd_mix;
    import jtcontra_snd_pkg::*;

    localparam int SH = 8;
    localparam int YW = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_in = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic [7:0]  gain = GAIN_UNITY;

    logic [15:0] sl0, sr0, sl1, sr1;
    logic        s0, s1, o0, o1;

    jtcontra_snd_mix #(.DC_SHIFT(SH), .DC_EN(0), .YW(YW)) dut0 (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .left_in(left_in), .right_in(right_in),
        .gain(gain), .mute(mute),
        .snd_left(sl0), .snd_right(sr0),
        .sample(s0), .overrun(o0)
    );

    jtcontra_snd_mix #(.DC_SHIFT(SH), .DC_EN(1), .YW(YW)) dut1 (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .left_in(left_in), .right_in(right_in),
        .gain(gain), .mute(mute),
        .snd_left(sl1), .snd_right(sr1),
        .sample(s1), .overrun(o1)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int hx[2];
    int hy[2];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int clip(input int v, input int bits);
        int mx;
        int mn;
        mx = (1 <<< (bits - 1)) - 1;
        mn = -(1 <<< (bits - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic int amp(input int y, input int g);
        int ys;
        ys = clip(y, 16);
        return clip((ys * g) >>> 4, 16);
    endfunction

    function automatic int dc(input int c, input int x);
        int y;
        y = x - hx[c] + hy[c] - (hy[c] >>> SH);
        y = clip(y, YW);
        hx[c] = x;
        hy[c] = y;
        return y;
    endfunction

    task automatic model_reset();
        hx[0] = 0; hx[1] = 0;
        hy[0] = 0; hy[1] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input int l, input int r, output int obs1l);
        int el0, er0, el1, er1, yl, yr, g;
        int ol0, or0, ol1, or1;
        logic [5:0] p0, p1;
        g   = int'(gain);
        el0 = mute ? 0 : amp(l, g);
        er0 = mute ? 0 : amp(r, g);
        yl  = dc(0, l);
        yr  = dc(1, r);
        el1 = mute ? 0 : amp(yl, g);
        er1 = mute ? 0 : amp(yr, g);
        ol0 = 0; or0 = 0; ol1 = 0; or1 = 0;
        @(negedge clk);
        left_in   = l[15:0];
        right_in  = r[15:0];
        sample_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) sample_in = 1'b0;
            p0[i] = s0;
            p1[i] = s1;
            if (i == 4) begin
                ol0 = $signed(sl0);
                or0 = $signed(sr0);
                ol1 = $signed(sl1);
                or1 = $signed(sr1);
            end
        end
        check("pulse_byp", int'(p0), 16);
        check("pulse_dc", int'(p1), 16);
        check("left_byp", ol0, el0);
        check("right_byp", or0, er0);
        check("left_dc", ol1, el1);
        check("right_dc", or1, er1);
        obs1l = ol1;
    endtask

    initial begin
        int o, prev, pulses, cap, el;

        model_reset();
        do_reset();
        check("rst_left0", int'(sl0), 0);
        check("rst_right1", int'(sr1), 0);
        check("rst_sample", int'(s0) + int'(s1), 0);
        check("rst_overrun", int'(o0) + int'(o1), 0);

        gain = GAIN_UNITY;
        send(1000, -1000, o);

        gain = 8'hFF;
        send(int'(S16_MAX), int'(S16_MIN), o);
        gain = 8'h08;
        send(-3, 3, o);

        for (int k = 0; k < 60; k++) begin
            gain = 8'($urandom_range(0, 255));
            mute = ($urandom_range(0, 3) == 0);
            send(int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, o);
        end
        mute = 1'b0;
        gain = 8'h00;
        send(12345, -12345, o);

        do_reset();
        gain = GAIN_UNITY;
        prev = 32767;
        for (int k = 0; k < 2000; k++) begin
            send(4000, -4000, o);
            check("decay_mono", int'(o <= prev), 1);
            prev = o;
        end
        check("decay_floor", int'(o >= 0 && o < 256), 1);

        do_reset();
        el = amp(dc(0, 1234), int'(gain));
        cap = 0;
        @(negedge clk);
        left_in = 16'd1234; right_in = 16'hFDD5; sample_in = 1'b1;
        @(negedge clk);
        sample_in = 1'b0;
        @(negedge clk);
        left_in = 16'd7777; right_in = 16'd7777; sample_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample_in = 1'b0;
            if (s1) begin
                pulses++;
                cap = $signed(sl1);
            end
        end
        void'(dc(1, -555));
        check("ovr_pulses", pulses, 1);
        check("ovr_value", cap, el);
        check("ovr_flag_byp", int'(o0), 1);
        check("ovr_flag_dc", int'(o1), 1);
        send(-2000, 2000, o);
        check("ovr_sticky", int'(o1), 1);
        do_reset();
        check("ovr_clear", int'(o0) + int'(o1), 0);

        mute = 1'b1;
        for (int k = 0; k < 10; k++) send(4000, 4000, o);
        mute = 1'b0;
        send(4000, 4000, o);

        send(1500, 1500, o);
        @(negedge clk);
        left_in = 16'd900; right_in = 16'd900; sample_in = 1'b1;
        @(negedge clk);
        sample_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s0 || s1) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_left", int'(sl1), 0);
        check("abort_right", int'(sr0), 0);
        send(500, -250, o);
        check("abort_hist", o, 500);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
